pipe_seg_skid: RTL and testbench

Parametrised handshake pipeline segment that generalises the fixed stall/refresh IF/ID register into a reusable two-entry elastic stage. Carries a DATA_W payload plus branch-delay-slot and exception tags between any two adjacent core stages (IF/ID, ID/EX, ...).
Replaces the global stall with per-stage valid/ready backpressure. A skid entry keeps the upstream ready from being a combinational function of the downstream ready. Flush still has single-cycle kill semantics.

---
 rtl/pipe_seg_skid_pkg.sv | 15 +
 rtl/pipe_seg_entry.sv | 47 ++++
 rtl/pipe_seg_skid.sv | 120 ++++++++++++
 tb/tb_pipe_seg_skid.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seg_skid_pkg.sv
// Shared core constants for the elastic pipeline segment and its storage slot.
package pipe_seg_skid_pkg;

  // Default payload width: a program counter.
  localparam int PC_W = 32;

  // Exception tag bit positions.
  localparam int EXC_ADDR_ERR = 0;

  // Occupancy of the two-entry stage from its two valid bits.
  function automatic logic [1:0] occupancy(input logic main_valid, input logic skid_valid);
    return {1'b0, main_valid} + {1'b0, skid_valid};
  endfunction

endpackage

// File: rtl/pipe_seg_entry.sv
// One storage slot of the segment: payload record {data, exc, bd} plus a valid bit.
// Load wins over clear; clear drops only the valid bit and keeps the payload.
module pipe_seg_entry
  import pipe_seg_skid_pkg::*;
#(
  parameter int DATA_W = PC_W,
  parameter int EXC_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] next_data,
  input  logic [EXC_W-1:0]  next_exc,
  input  logic              next_bd,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [EXC_W-1:0]  exc,
  output logic              bd
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } entry_t;

  entry_t slot;

  // Slot register: reset clears everything, load captures a beat, clear only invalidates.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      slot  <= '{data: next_data, exc: next_exc, bd: next_bd};
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign data = slot.data;
  assign exc  = slot.exc;
  assign bd   = slot.bd;

endmodule

// File: rtl/pipe_seg_skid.sv
// Two-entry elastic pipeline segment (main + skid) with valid/ready handshake,
// branch-delay-slot tagging and single-cycle flush. in_ready depends only on
// the skid valid flop, so it never combinationally follows out_ready.
module pipe_seg_skid
  import pipe_seg_skid_pkg::*;
#(
  parameter int DATA_W   = PC_W,
  parameter int EXC_W    = 1,
  parameter int TRACK_BD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_branch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        count
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [EXC_W-1:0]  skid_exc;
  logic              skid_bd;
  logic              last_br;

  logic              accept;
  logic              pop;
  logic              take;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] main_next_data;
  logic [EXC_W-1:0]  main_next_exc;
  logic              main_next_bd;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign take     = accept & ~flush;
  assign count    = occupancy(out_valid, skid_valid);

  // Slot control: decide which entry loads and where the main entry is refilled from.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_next_data = in_data;
    main_next_exc  = in_exc;
    main_next_bd   = last_br;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!out_valid) begin
      main_load = take;
    end else if (pop) begin
      if (take) begin
        main_load = 1'b1;
      end else if (skid_valid) begin
        main_load      = 1'b1;
        main_next_data = skid_data;
        main_next_exc  = skid_exc;
        main_next_bd   = skid_bd;
        skid_clear     = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (take) begin
      skid_load = 1'b1;
    end
  end

  // Remember whether the last accepted beat was a branch; the next accepted beat is its delay slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_br <= 1'b0;
    end else if (flush) begin
      last_br <= 1'b0;
    end else if (take) begin
      last_br <= (TRACK_BD != 0) && in_branch;
    end
  end

  pipe_seg_entry #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .next_data (main_next_data),
    .next_exc  (main_next_exc),
    .next_bd   (main_next_bd),
    .valid     (out_valid),
    .data      (out_data),
    .exc       (out_exc),
    .bd        (out_bd)
  );

  pipe_seg_entry #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .next_data (in_data),
    .next_exc  (in_exc),
    .next_bd   (last_br),
    .valid     (skid_valid),
    .data      (skid_data),
    .exc       (skid_exc),
    .bd        (skid_bd)
  );

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Self-checking bench for pipe_seg_skid: directed scenarios followed by random
// traffic, all compared against a queue-based model of a two-deep FIFO stage.
module tb_pipe_seg_skid;
  import pipe_seg_skid_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [0:0]  in_exc = '0;
  logic        in_branch = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_bd;
  logic [31:0] out_data;
  logic [0:0]  out_exc;
  logic [1:0]  count;

  logic        nb_in_ready, nb_out_valid, nb_out_bd;
  logic [31:0] nb_out_data;
  logic [0:0]  nb_out_exc;
  logic [1:0]  nb_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        exc;
    logic        bd;
  } beat_t;

  beat_t mq[$];
  bit    m_last_br = 1'b0;
  bit    m_clean = 1'b0;
  bit    known = 1'b0;

  always #5 clk = ~clk;

  pipe_seg_skid #(.DATA_W(32), .EXC_W(1), .TRACK_BD(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_exc(in_exc), .in_branch(in_branch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc(out_exc), .out_bd(out_bd), .count(count)
  );

  pipe_seg_skid #(.DATA_W(32), .EXC_W(1), .TRACK_BD(0)) dut_nb (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nb_in_ready), .in_data(in_data),
    .in_exc(in_exc), .in_branch(in_branch),
    .out_valid(nb_out_valid), .out_ready(out_ready), .out_data(nb_out_data),
    .out_exc(nb_out_exc), .out_bd(nb_out_bd), .count(nb_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic applyStimulus(input bit rst, input bit fl, input bit iv, input logic [31:0] d,
                               input bit e, input bit br, input bit ordy, output bit acc);
    @(negedge clk);
    if (known) begin
      checkOutput("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      checkOutput("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      checkOutput("count", 64'(count), 64'(mq.size()));
      if (mq.size() > 0) begin
        checkOutput("out_data", 64'(out_data), 64'(mq[0].data));
        checkOutput("out_exc", 64'(out_exc), 64'(mq[0].exc));
        checkOutput("out_bd", 64'(out_bd), 64'(mq[0].bd));
      end else if (m_clean) begin
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_exc", 64'(out_exc), 64'd0);
        checkOutput("rst_bd", 64'(out_bd), 64'd0);
      end
      checkOutput("nb_out_bd", 64'(nb_out_bd), 64'd0);
      checkOutput("nb_count", 64'(nb_count), 64'(mq.size()));
      if (mq.size() > 0) begin
        checkOutput("nb_out_data", 64'(nb_out_data), 64'(mq[0].data));
      end
    end
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    in_exc    = e;
    in_branch = br;
    out_ready = ordy;
    acc = !rst && !fl && iv && (mq.size() < 2);
    if (rst) begin
      mq.delete();
      m_last_br = 1'b0;
      m_clean   = 1'b1;
      known     = 1'b1;
    end else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{data: d, exc: e, bd: m_last_br});
        m_last_br = br;
        m_clean   = 1'b0;
      end
      if (fl) begin
        mq.delete();
        m_last_br = 1'b0;
      end
    end
  endtask

  // Offer one beat until accepted, with a bounded number of attempts.
  task automatic pushBeat(input logic [31:0] d, input bit e, input bit br, input bit ordy, input bit rnd_ready);
    bit acc;
    bit r;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      r = rnd_ready ? bit'($urandom_range(0, 1)) : ordy;
      applyStimulus(1'b0, 1'b0, 1'b1, d, e, br, r, acc);
    end
    if (!acc) checkOutput("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ordy, acc);
  endtask

  initial begin
    bit acc;
    bit rr, ff, vv, oo;

    // Power-up reset
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b1);

    // Back-to-back streaming
    pushBeat(32'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
    pushBeat(32'h1004, 1'b0, 1'b0, 1'b1, 1'b0);
    pushBeat(32'h1008, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Downstream stall fills both entries, third beat held upstream
    pushBeat(32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    pushBeat(32'h1004, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1008, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("held_0", 64'(acc), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1008, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("held_1", 64'(acc), 64'd0);
    pushBeat(32'h1008, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Delay-slot tagging
    pushBeat(32'h2000, 1'b0, 1'b1, 1'b1, 1'b0);
    pushBeat(32'h2004, 1'b0, 1'b0, 1'b1, 1'b0);
    pushBeat(32'h2008, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Flush with a full stage and an offered beat; branch history is killed
    pushBeat(32'h2100, 1'b0, 1'b0, 1'b0, 1'b0);
    pushBeat(32'h2104, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, acc);
    pushBeat(32'h3004, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Exception tag travels with its beat under random backpressure
    pushBeat(32'h0FF8, 1'b0, 1'b0, 1'b0, 1'b1);
    pushBeat(32'h0FFC, 1'b0, 1'b0, 1'b0, 1'b1);
    pushBeat(32'h0FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    pushBeat(32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-operation with a full stage and a pending delay slot
    pushBeat(32'h4000, 1'b0, 1'b1, 1'b0, 1'b0);
    pushBeat(32'h4004, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    pushBeat(32'h4008, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 127) == 0);
      ff = ($urandom_range(0, 15) == 0);
      vv = ($urandom_range(0, 3) != 0);
      oo = ($urandom_range(0, 2) != 0);
      applyStimulus(rr, ff, vv, $urandom, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), oo, acc);
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
